// File: rtl/plot_pkg.sv
// Shared screen limits, field-width defaults and FSM state encoding for the plot arbiter.
package plot_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;

    localparam int N_REQ_DEF = 3;
    localparam int X_W_DEF   = 8;
    localparam int Y_W_DEF   = 7;
    localparam int C_W_DEF   = 3;
    localparam int S_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLOT = 2'd1,
        ST_DONE = 2'd2
    } plot_state_t;

endpackage

// File: rtl/plot_arbiter_if.sv
// Requester job bus plus adapter pixel port of the plot arbiter.
interface plot_arbiter_if
    import plot_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int C_W   = C_W_DEF,
    parameter int S_W   = S_W_DEF
) ();

    logic [N_REQ-1:0]     req;
    logic [N_REQ*X_W-1:0] req_x;
    logic [N_REQ*Y_W-1:0] req_y;
    logic [N_REQ*S_W-1:0] req_w;
    logic [N_REQ*S_W-1:0] req_h;
    logic [N_REQ*C_W-1:0] req_colour;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     done;
    logic                 busy;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [C_W-1:0]       colour;
    logic                 plot;

    modport master (
        output req, req_x, req_y, req_w, req_h, req_colour,
        input  grant, done, busy, x, y, colour, plot
    );

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_colour,
        output grant, done, busy, x, y, colour, plot
    );

endinterface

// File: rtl/plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
module rr_pick
    import plot_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx
);

    int               j;
    logic [IDX_W-1:0] jj;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        j          = 0;
        jj         = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            jj = IDX_W'(j);
            if (req[jj]) begin
                winner     = '0;
                winner[jj] = 1'b1;
                winner_idx = jj;
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin arbiter rasterising one filled rectangle at a time onto the VGA plot port.
// Optional build macro PLOT_ARB_CLIP_EN suppresses plot for pixels off the 160x120 screen.
//
// state | meaning
// IDLE  | waiting for any req; picks a winner and latches its job
// PLOT  | one pixel per cycle, row-major over (w+1)x(h+1)
// DONE  | done pulse to owner, advance rr pointer, release grant
module plot_arbiter
    import plot_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int C_W   = C_W_DEF,
    parameter int S_W   = S_W_DEF
) (
    input logic           clk,
    input logic           resetn,
    plot_arbiter_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef PLOT_ARB_CLIP_EN
    localparam int PXW = X_W + 1;
    localparam int PYW = Y_W + 1;
`else
    localparam int PXW = X_W;
    localparam int PYW = Y_W;
`endif

    plot_state_t      state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] g_idx_q, g_idx_d;
    logic [X_W-1:0]   x0_q, x0_d;
    logic [Y_W-1:0]   y0_q, y0_d;
    logic [S_W-1:0]   w_q, w_d, h_q, h_d;
    logic [S_W-1:0]   col_q, col_d, row_q, row_d;
    logic [C_W-1:0]   colour_q, colour_d;
    logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
    logic             busy_q, busy_d, plot_q, plot_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    logic             emit;
    logic [X_W-1:0]   ex0;
    logic [Y_W-1:0]   ey0;
    logic [S_W-1:0]   ecol, erow;
    logic [PXW-1:0]   px;
    logic [PYW-1:0]   py;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (bus.req),
        .rr_ptr     (rr_ptr_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx)
    );

    assign pick_valid = |pick_onehot;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            g_idx_q  <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            colour_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            g_idx_q  <= g_idx_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            col_q    <= col_d;
            row_q    <= row_d;
            colour_q <= colour_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    // Outputs are registered, so each branch prepares the pixel shown in the following cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        g_idx_d  = g_idx_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        col_d    = col_q;
        row_d    = row_q;
        colour_d = colour_q;
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = busy_q;
        plot_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        emit     = 1'b0;
        ex0      = '0;
        ey0      = '0;
        ecol     = '0;
        erow     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    x0_d     = bus.req_x[int'(pick_idx)*X_W +: X_W];
                    y0_d     = bus.req_y[int'(pick_idx)*Y_W +: Y_W];
                    w_d      = bus.req_w[int'(pick_idx)*S_W +: S_W];
                    h_d      = bus.req_h[int'(pick_idx)*S_W +: S_W];
                    colour_d = bus.req_colour[int'(pick_idx)*C_W +: C_W];
                    g_idx_d  = pick_idx;
                    grant_d  = pick_onehot;
                    busy_d   = 1'b1;
                    col_d    = '0;
                    row_d    = '0;
                    state_d  = ST_PLOT;
                    emit     = 1'b1;
                    ex0      = x0_d;
                    ey0      = y0_d;
                end
            end
            ST_PLOT: begin
                if (col_q == w_q && row_q == h_q) begin
                    done_d  = grant_q;
                    state_d = ST_DONE;
                end else begin
                    if (col_q == w_q) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    emit = 1'b1;
                    ex0  = x0_q;
                    ey0  = y0_q;
                    ecol = col_d;
                    erow = row_d;
                end
            end
            ST_DONE: begin
                grant_d  = '0;
                busy_d   = 1'b0;
                rr_ptr_d = (g_idx_q == IDX_W'(N_REQ - 1)) ? '0 : g_idx_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        px = PXW'(ex0) + PXW'(ecol);
        py = PYW'(ey0) + PYW'(erow);
        if (emit) begin
            x_d = px[X_W-1:0];
            y_d = py[Y_W-1:0];
`ifdef PLOT_ARB_CLIP_EN
            plot_d = (px < PXW'(SCREEN_W)) && (py < PYW'(SCREEN_H));
`else
            plot_d = 1'b1;
`endif
        end
    end

    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Bench for plot_arbiter: job-level reference model with per-cycle compare, directed scenarios and random traffic.
module tb_plot_arbiter;
    import plot_pkg::*;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    plot_arbiter_if #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .S_W(SW)) bus ();

    plot_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .S_W(SW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- reference model: whole jobs expanded into per-cycle expectations
    typedef struct {
        logic [N-1:0]  grant;
        logic [N-1:0]  done;
        logic          busy;
        logic          plot;
        logic          chk_pix;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] colour;
    } exp_t;

    function automatic exp_t mk(input logic [N-1:0] g, input logic [N-1:0] d, input logic b,
                                input logic p, input logic c, input int xv, input int yv, input int cv);
        exp_t e;
        e.grant = g; e.done = d; e.busy = b; e.plot = p; e.chk_pix = c;
        e.x = XW'(xv); e.y = YW'(yv); e.colour = CW'(cv);
        return e;
    endfunction

    exp_t q[$];
    exp_t cur;
    int   ptr = 0;
    bit   model_ok = 0;

    always @(posedge clk) begin
        if (!resetn) begin
            q.delete();
            ptr = 0;
            cur = mk('0, '0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        end else begin
            if (q.size() == 0) begin
                int win;
                win = -1;
                for (int k = 0; k < N; k++)
                    if (win < 0 && bus.req[(ptr + k) % N]) win = (ptr + k) % N;
                if (win >= 0) begin
                    int x0, y0, w, h, c;
                    logic [N-1:0] g;
                    x0 = int'(bus.req_x[win*XW +: XW]);
                    y0 = int'(bus.req_y[win*YW +: YW]);
                    w  = int'(bus.req_w[win*SW +: SW]);
                    h  = int'(bus.req_h[win*SW +: SW]);
                    c  = int'(bus.req_colour[win*CW +: CW]);
                    g  = '0;
                    g[win] = 1'b1;
                    for (int r = 0; r <= h; r++) begin
                        for (int cc = 0; cc <= w; cc++) begin
                            logic p;
`ifdef PLOT_ARB_CLIP_EN
                            p = (x0 + cc < SCREEN_W) && (y0 + r < SCREEN_H);
`else
                            p = 1'b1;
`endif
                            q.push_back(mk(g, '0, 1'b1, p, p, x0 + cc, y0 + r, c));
                        end
                    end
                    q.push_back(mk(g, g, 1'b1, 1'b0, 1'b0, 0, 0, 0));
                    q.push_back(mk('0, '0, 1'b0, 1'b0, 1'b0, 0, 0, 0));
                    ptr = (win + 1) % N;
                end
            end
            if (q.size() > 0) cur = q.pop_front();
            else cur = mk('0, '0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        end
        model_ok = 1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("grant", bus.grant, cur.grant);
            chk("done", bus.done, cur.done);
            chk("busy", bus.busy, cur.busy);
            chk("plot", bus.plot, cur.plot);
            if (cur.chk_pix) begin
                chk("x", bus.x, cur.x);
                chk("y", bus.y, cur.y);
                chk("colour", bus.colour, cur.colour);
            end
        end
    end

    // ---------------- observation counters for the hand-computed checks
    int n_plot, n_busy, first_plot_cyc;
    int n_done[N];
    int first_x, first_y, last_x, last_y;
    int done_cyc[$];
    int order[$];
    logic [N-1:0] prev_grant = '0;

    task automatic clear_mon();
        n_plot = 0; n_busy = 0; first_plot_cyc = -1;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        for (int i = 0; i < N; i++) n_done[i] = 0;
        done_cyc.delete();
        order.delete();
    endtask

    always @(negedge clk) begin
        if (bus.plot === 1'b1) begin
            if (n_plot == 0) begin
                first_plot_cyc = cyc; first_x = int'(bus.x); first_y = int'(bus.y);
            end
            last_x = int'(bus.x); last_y = int'(bus.y);
            n_plot++;
        end
        if (bus.busy === 1'b1) n_busy++;
        for (int i = 0; i < N; i++)
            if (bus.done[i] === 1'b1) begin n_done[i]++; done_cyc.push_back(cyc); end
        if (bus.grant != '0 && prev_grant == '0)
            for (int i = 0; i < N; i++) if (bus.grant[i]) order.push_back(i);
        prev_grant = bus.grant;
    end

    // ---------------- stimulus helpers
    logic [N-1:0] drop_mask = '1;

    task automatic step();
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (drop_mask[i] && bus.done[i] === 1'b1) bus.req[i] = 1'b0;
    endtask

    task automatic set_job(input int i, input int xv, input int yv, input int w, input int h, input int c);
        bus.req_x[i*XW +: XW]      = XW'(xv);
        bus.req_y[i*YW +: YW]      = YW'(yv);
        bus.req_w[i*SW +: SW]      = SW'(w);
        bus.req_h[i*SW +: SW]      = SW'(h);
        bus.req_colour[i*CW +: CW] = CW'(c);
        bus.req[i] = 1'b1;
    endtask

    task automatic run_until_quiet(input string name, input int budget);
        int n;
        n = 0;
        step();
        while ((bus.busy !== 1'b0 || bus.req != '0) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, (n < budget) ? 1 : 0, 1);
    endtask

    initial begin
        int set_cyc, n;
        bus.req = '0; bus.req_x = '0; bus.req_y = '0;
        bus.req_w = '0; bus.req_h = '0; bus.req_colour = '0;
        clear_mon();
        repeat (3) step();

        chk("rst_grant", bus.grant, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_plot", bus.plot, 0);
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_colour", bus.colour, 0);
        resetn = 1'b1;
        step();

        // single 16x4 job from requester 1
        clear_mon();
        set_cyc = cyc;
        set_job(1, 32, 8, 15, 3, 5);
        run_until_quiet("single", 300);
        chk("single_plots", n_plot, 64);
        chk("single_busy", n_busy, 65);
        chk("single_done1", n_done[1], 1);
        chk("single_first_lat", first_plot_cyc - set_cyc, 1);
        chk("single_first_x", first_x, 32);
        chk("single_first_y", first_y, 8);
        chk("single_last_x", last_x, 47);
        chk("single_last_y", last_y, 11);
        chk("single_ndone", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("single_done_lat", done_cyc[0] - set_cyc, 65);

        // contention: all three pending when reset releases
        resetn = 1'b0;
        step();
        set_job(0, 0, 0, 1, 1, 1);
        set_job(1, 10, 10, 1, 1, 2);
        set_job(2, 20, 20, 1, 1, 3);
        clear_mon();
        resetn = 1'b1;
        run_until_quiet("contend", 100);
        chk("contend_njobs", order.size(), 3);
        if (order.size() == 3) begin
            chk("contend_order0", order[0], 0);
            chk("contend_order1", order[1], 1);
            chk("contend_order2", order[2], 2);
        end
        chk("contend_plots", n_plot, 12);
        if (done_cyc.size() == 3) begin
            chk("contend_gap01", done_cyc[1] - done_cyc[0], 6);
            chk("contend_gap12", done_cyc[2] - done_cyc[1], 6);
        end

        // fairness: requester 0 keeps requesting while 2 pends
        clear_mon();
        drop_mask = 3'b110;
        set_job(0, 50, 50, 1, 1, 6);
        set_job(2, 60, 60, 1, 1, 7);
        n = 0;
        while (n_done[0] < 2 && n < 100) begin step(); n++; end
        chk("fair_timeout", (n < 100) ? 1 : 0, 1);
        bus.req[0] = 1'b0;
        drop_mask = '1;
        run_until_quiet("fair", 100);
        chk("fair_njobs", order.size(), 3);
        if (order.size() == 3) begin
            chk("fair_order0", order[0], 0);
            chk("fair_order1", order[1], 2);
            chk("fair_order2", order[2], 0);
        end

        // off-screen rectangle
        clear_mon();
        set_job(0, 152, 118, 15, 3, 2);
        run_until_quiet("clip", 300);
        chk("clip_busy", n_busy, 65);
        chk("clip_first_x", first_x, 152);
        chk("clip_first_y", first_y, 118);
`ifdef PLOT_ARB_CLIP_EN
        chk("clip_plots", n_plot, 16);
        chk("clip_last_x", last_x, 159);
        chk("clip_last_y", last_y, 119);
`else
        chk("clip_plots", n_plot, 64);
        chk("clip_last_x", last_x, 167);
        chk("clip_last_y", last_y, 121);
`endif

        // reset at the 10th pixel of a 16x4 job
        clear_mon();
        set_job(2, 10, 10, 15, 3, 1);
        n = 0;
        while (n_plot < 10 && n < 100) begin step(); n++; end
        chk("rstjob_timeout", (n < 100) ? 1 : 0, 1);
        resetn = 1'b0;
        bus.req = '0;
        step();
        chk("rstjob_plot", bus.plot, 0);
        chk("rstjob_grant", bus.grant, 0);
        chk("rstjob_busy", bus.busy, 0);
        chk("rstjob_done", bus.done, 0);
        resetn = 1'b1;
        step();
        chk("rstjob_nodone", n_done[2], 0);
        clear_mon();
        set_job(0, 1, 1, 1, 1, 3);
        set_job(2, 5, 5, 1, 1, 4);
        run_until_quiet("rstjob_after", 100);
        if (order.size() > 0) chk("rstjob_first_grant", order[0], 0);
        else chk("rstjob_first_grant_seen", 0, 1);

        // field change mid-job is ignored
        clear_mon();
        set_job(1, 40, 20, 3, 1, 4);
        repeat (3) step();
        bus.req_x[1*XW +: XW] = 8'd100;
        bus.req_y[1*YW +: YW] = 7'd90;
        run_until_quiet("fieldchg", 100);
        chk("fieldchg_plots", n_plot, 8);
        chk("fieldchg_last_x", last_x, 43);
        chk("fieldchg_last_y", last_y, 21);

        // random traffic against the model
        for (int t = 0; t < 5000; t++) begin
            step();
            if (resetn == 1'b0) begin
                resetn = 1'b1;
            end else if ($urandom_range(0, 1499) == 0) begin
                resetn = 1'b0;
                bus.req = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (bus.req[i] == 1'b0 && bus.grant[i] == 1'b0) begin
                        if ($urandom_range(0, 7) == 0)
                            set_job(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                                    int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                                    int'($urandom_range(0, 7)));
                    end else if (bus.grant[i] == 1'b0) begin
                        if ($urandom_range(0, 39) == 0) bus.req[i] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        bus.req_x[i*XW +: XW] = XW'($urandom);
                        bus.req_w[i*SW +: SW] = SW'($urandom);
                    end
                end
            end
        end
        resetn = 1'b1;
        bus.req = '0;
        run_until_quiet("random_drain", 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
